// File: rtl/key_event_fifo.sv
// key_event_fifo: turns a held game key level into press/repeat events
// and queues them in a first-word fall-through FIFO. Optional macro: KEY_RELEASE_EVT_EN
module key_event_fifo #(
   parameter int DEPTH         = 8,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000,
   parameter int REPEAT_ON     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_code,
   input  logic       rd_en,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic [4:0] count,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      prev_code_q, prev_code_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [4:0]      count_q, count_d;
   logic            overflow_q, overflow_d;

   logic [3:0]      code_s;
   logic            push_req;
   logic [7:0]      push_data;
   logic            pop;
   logic            push;
   logic            drop;
   logic            full_w;
   logic            empty_w;

   // Fold anything outside the valid key range into "no key".
   always_comb begin
      code_s = 4'd0;
      if (key_code >= 8'd1 && key_code <= 8'd8) begin
         code_s = key_code[3:0];
      end
      prev_code_d = code_s;
   end

   // Edge detection and auto-repeat timing; at most one event per cycle.
   always_comb begin
      push_req  = 1'b0;
      push_data = 8'd0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      if (code_s == 4'd0) begin
         state_d = IDLE;
         cnt_d   = '0;
`ifdef KEY_RELEASE_EVT_EN
         if (prev_code_q != 4'd0) begin
            push_req  = 1'b1;
            push_data = {4'b0100, prev_code_q};
         end
`endif
      end else if (code_s != prev_code_q) begin
         push_req  = 1'b1;
         push_data = {4'b0000, code_s};
         cnt_d     = '0;
         state_d   = (REPEAT_ON != 0) ? DELAY : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
            end
            DELAY: begin
               if (cnt_q == DLY_LAST) begin
                  push_req  = 1'b1;
                  push_data = {4'b1000, code_s};
                  state_d   = REPEAT;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            REPEAT: begin
               if (cnt_q == PER_LAST) begin
                  push_req  = 1'b1;
                  push_data = {4'b1000, code_s};
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Queue bookkeeping: a pop frees a slot in the same cycle, so a push
   // into a full FIFO only drops when nothing is being read.
   always_comb begin
      full_w     = (count_q == DEPTH_C);
      empty_w    = (count_q == 5'd0);
      pop        = rd_en && !empty_w;
      push       = push_req && (!full_w || pop);
      drop       = push_req && full_w && !pop;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 5'd1;
      end else if (pop && !push) begin
         count_d = count_q - 5'd1;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Fall-through head: dout is forced to zero whenever the queue is empty.
   always_comb begin
      dout     = empty_w ? 8'd0 : mem_q[rd_ptr_q];
      empty    = empty_w;
      full     = full_w;
      count    = count_q;
      overflow = overflow_q;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prev_code_q <= 4'd0;
         mem_q       <= '{default: 8'd0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= 5'd0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_code_q <= prev_code_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

endmodule
